// File: rtl/value_display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment value display.
// The segment font is active-high; output polarity is applied at the top level.
package value_display_pkg;

  localparam int unsigned DIGITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_e;

  // Segment order is {g,f,e,d,c,b,a}; b and d use lowercase glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = 7'h00;
    case (nibble)
      4'h0: pat = 7'b0111111;
      4'h1: pat = 7'b0000110;
      4'h2: pat = 7'b1011011;
      4'h3: pat = 7'b1001111;
      4'h4: pat = 7'b1100110;
      4'h5: pat = 7'b1101101;
      4'h6: pat = 7'b1111101;
      4'h7: pat = 7'b0000111;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1101111;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b1111100;
      4'hC: pat = 7'b0111001;
      4'hD: pat = 7'b1011110;
      4'hE: pat = 7'b1111001;
      4'hF: pat = 7'b1110001;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, MSB first).
// The first shift happens on the start edge, so done pulses exactly 8 cycles after start.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [11:0] bcd_q;
  logic [7:0]  sh_q;
  logic [3:0]  cnt_q;

  function automatic logic [11:0] dabble(input logic [11:0] b, input logic b_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[10:0], b_in};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bcd_q <= dabble(12'h000, bin[7]);
      sh_q  <= {bin[6:0], 1'b0};
      cnt_q <= 4'd1;
    end else if (cnt_q == 4'd8) begin
      cnt_q <= '0;
    end else if (cnt_q != 4'd0) begin
      bcd_q <= dabble(bcd_q, sh_q[7]);
      sh_q  <= {sh_q[6:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Result is held in bcd_q after done until the next start.
  assign done     = (cnt_q == 4'd8);
  assign hundreds = bcd_q[11:8];
  assign tens     = bcd_q[7:4];
  assign ones     = bcd_q[3:0];

endmodule

// File: rtl/value_display_driver.sv
// Shows an 8-bit value on a 4-digit multiplexed 7-segment display in hex or decimal.
// Conversion runs on change; the digit set switches atomically at commit.
module value_display_driver
  import value_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam logic [15:0] PrescMax = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SegOff   = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic        DpOff    = SEG_ACTIVE_LOW;
  localparam logic [3:0]  AnOff    = AN_ACTIVE_LOW ? 4'hf : 4'h0;

  state_e                    state_q;
  logic [7:0]                snap_value_q, shown_value_q;
  logic                      snap_mode_q, shown_mode_q;
  logic [DIGITS-1:0][3:0]    digit_q, digit_d;
  logic [DIGITS-1:0]         blank_q, blank_d;
  logic                      disp_mode;
  logic [15:0]               presc_q;
  logic [1:0]                scan_q;
  logic [6:0]                seg_q;
  logic                      dp_q;
  logic [3:0]                an_q;

  logic                      changed, start, bcd_done;
  logic [3:0]                bcd_h, bcd_t, bcd_o;
  logic [6:0]                slot_seg;
  logic [3:0]                slot_an;
  logic                      slot_dp;

  assign changed = (value != shown_value_q) || (mode != shown_mode_q);
  assign start   = (state_q == StIdle) && changed && mode;
  assign busy    = (state_q != StIdle);

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (value),
    .done     (bcd_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  // During COMMIT the display path already sees the new digit set, so the output register
  // picks it up on the same edge that commits it.
  always_comb begin
    digit_d   = digit_q;
    blank_d   = blank_q;
    disp_mode = shown_mode_q;
    if (state_q == StCommit) begin
      disp_mode = snap_mode_q;
      if (snap_mode_q) begin
        digit_d = {4'h0, bcd_h, bcd_t, bcd_o};
        blank_d = {1'b1, bcd_h == 4'h0, (bcd_h == 4'h0) && (bcd_t == 4'h0), 1'b0};
      end else begin
        digit_d = {4'h0, 4'h0, snap_value_q[7:4], snap_value_q[3:0]};
        blank_d = 4'b1100;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      snap_value_q  <= '0;
      snap_mode_q   <= 1'b0;
      shown_value_q <= '0;
      shown_mode_q  <= 1'b0;
      digit_q       <= '0;
      blank_q       <= 4'b1100;
    end else begin
      case (state_q)
        StIdle: begin
          if (changed) begin
            snap_value_q <= value;
            snap_mode_q  <= mode;
            state_q      <= StConv;
          end
        end
        StConv: begin
          if (!snap_mode_q || bcd_done) state_q <= StCommit;
        end
        StCommit: begin
          shown_value_q <= snap_value_q;
          shown_mode_q  <= snap_mode_q;
          digit_q       <= digit_d;
          blank_q       <= blank_d;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    slot_seg = blank_d[scan_q] ? 7'h00 : hex_to_seg(digit_d[scan_q]);
    slot_an  = blank_d[scan_q] ? 4'b0000 : (4'b0001 << scan_q);
    slot_dp  = !blank_d[scan_q] && (scan_q == 2'd0) && !disp_mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      seg_q   <= SegOff;
      dp_q    <= DpOff;
      an_q    <= AnOff;
    end else begin
      if (presc_q == PrescMax) begin
        presc_q <= '0;
        scan_q  <= scan_q + 2'd1;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
      seg_q <= SEG_ACTIVE_LOW ? ~slot_seg : slot_seg;
      dp_q  <= SEG_ACTIVE_LOW ? ~slot_dp : slot_dp;
      an_q  <= AN_ACTIVE_LOW ? ~slot_an : slot_an;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_value_display_driver.sv
// Randomized self-checking bench for value_display_driver (SCAN_DIV = 2, active-low outputs).
// Expected digits come from plain arithmetic on the last committed value/mode.
module tb_value_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'h00;
  logic       mode = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] e_seg [4];
  logic [3:0] e_vis;
  logic       e_dp;
  logic [3:0] seen;
  logic [7:0] shown_v;
  logic       shown_m;

  value_display_driver #(
    .SCAN_DIV       (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .mode  (mode),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] font(input int n);
    case (n)
      0: return 7'b0111111;   1: return 7'b0000110;   2: return 7'b1011011;
      3: return 7'b1001111;   4: return 7'b1100110;   5: return 7'b1101101;
      6: return 7'b1111101;   7: return 7'b0000111;   8: return 7'b1111111;
      9: return 7'b1101111;   10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001;  13: return 7'b1011110;  14: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic set_expect(input logic [7:0] v, input logic m);
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    for (int i = 0; i < 4; i++) e_seg[i] = 7'h00;
    if (!m) begin
      e_seg[0] = font(int'(v) % 16);
      e_seg[1] = font(int'(v) / 16);
      e_vis    = 4'b0011;
      e_dp     = 1'b1;
    end else begin
      e_seg[0] = font(o);
      e_seg[1] = font(t);
      e_seg[2] = font(h);
      e_vis    = {1'b0, h != 0, (h != 0) || (t != 0), 1'b1};
      e_dp     = 1'b0;
    end
  endtask

  // One sample of the scanned outputs against the current expected digit set.
  task automatic check_sample();
    logic [3:0] act;
    logic [6:0] lit;
    logic       dpl;
    int         k;
    act = ~an;
    lit = ~seg;
    dpl = ~dp;
    k = 0;
    for (int i = 0; i < 4; i++) if (act[i]) k = i;
    if (act == 4'b0000) begin
      check_eq("blank_seg", {25'b0, lit}, 32'h0);
      check_eq("blank_dp", {31'b0, dpl}, 32'h0);
    end else if ($onehot(act)) begin
      check_eq("an_visible", {31'b0, e_vis[k]}, 32'h1);
      check_eq("seg", {25'b0, lit}, {25'b0, e_seg[k]});
      check_eq("dp", {31'b0, dpl}, {31'b0, (k == 0) && e_dp});
      seen[k] = 1'b1;
    end else begin
      check_eq("an_onehot", {28'b0, act}, 32'h0);
    end
  endtask

  task automatic check_frame(input int cycles);
    seen = 4'b0000;
    repeat (cycles) begin
      check_sample();
      check_eq("idle_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
    end
    check_eq("digits_seen", {28'b0, seen}, {28'b0, e_vis});
  endtask

  // Counts busy cycles while checking that the old digits stay on display.
  task automatic measure_busy(output int n, input int chg_at, input logic [7:0] chg_val);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      check_sample();
      n++;
      if (n == chg_at) value = chg_val;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input logic [7:0] v, input logic m);
    int n, exp_busy;
    exp_busy = (v != shown_v || m != shown_m) ? (m ? 9 : 2) : 0;
    value = v;
    mode  = m;
    measure_busy(n, -1, 8'h00);
    check_eq("busy_len", n, exp_busy);
    shown_v = v;
    shown_m = m;
    set_expect(v, m);
    check_frame(12);
  endtask

  initial begin
    int n;
    logic [7:0] rv;
    logic       rm;

    // Reset state
    set_expect(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_seg", {25'b0, seg}, 32'h7f);
    check_eq("rst_dp", {31'b0, dp}, 32'h1);
    check_eq("rst_an", {28'b0, an}, 32'hf);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    shown_v = 8'h00;
    shown_m = 1'b0;
    check_frame(12);

    run_txn(8'hA5, 1'b0);
    run_txn(8'd255, 1'b1);
    run_txn(8'd7, 1'b1);
    run_txn(8'd0, 1'b1);

    // Value changes mid-conversion: 100 is committed first, then 42 follows.
    value = 8'd100;
    mode  = 1'b1;
    measure_busy(n, 3, 8'd42);
    check_eq("busy_len_100", n, 9);
    set_expect(8'd100, 1'b1);
    check_sample();
    measure_busy(n, -1, 8'h00);
    check_eq("busy_len_42", n, 9);
    shown_v = 8'd42;
    shown_m = 1'b1;
    set_expect(8'd42, 1'b1);
    check_frame(12);

    // Reset in the middle of a conversion
    value = 8'h3C;
    mode  = 1'b0;
    @(negedge clk);
    check_eq("conv_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_seg", {25'b0, seg}, 32'h7f);
    check_eq("midrst_dp", {31'b0, dp}, 32'h1);
    check_eq("midrst_an", {28'b0, an}, 32'hf);
    check_eq("midrst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    shown_v = 8'h00;
    shown_m = 1'b0;
    set_expect(8'h00, 1'b0);
    measure_busy(n, -1, 8'h00);
    check_eq("busy_len_3c", n, 2);
    shown_v = 8'h3C;
    set_expect(8'h3C, 1'b0);
    check_frame(12);

    for (int i = 0; i < 24; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? shown_v : 8'($urandom);
      rm = 1'($urandom);
      run_txn(rv, rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
